seq_multiplier: RTL
===================

Name: seq_multiplier

Overview:
- Parametrised sequential radix-2 shift-add multiplier. Successor to the team's combinational array multiplier.
- Adds runtime signed/unsigned mode, operand latching and a start/busy/done handshake.
- Used where an N×N array is too large in area: trades N+2 cycles of latency for one N-bit adder.
- Sits in the ALU datapath behind the operand registers; the product is held for the consumer until the next start.

Parameters:
- N, 8, operand width in bits; N >= 2; product width is 2N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with start.
- a  input  N  multiplicand; latched with start.
- b  input  N  multiplier; latched with start.
- busy  output  1  high while in CALC or FIX.
- done  output  1  one-cycle pulse marking that the product is valid.
- product  output  2N  result; held stable until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, product=0, counter=0, all internal registers=0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 at rising edge E is accepted, and the machine goes to CALC.
  - Latch signed_mode.
  - In signed mode, latch the magnitudes |a| and |b| as N-bit unsigned values (|-2^(N-1)| = 2^(N-1) fits). In unsigned mode, latch a and b directly.
  - Record neg = signed_mode & (a[N-1] ^ b[N-1]).
  - Clear the accumulator and set counter=0.
- CALC: one iteration per cycle for exactly N cycles.
  - If the current multiplier LSB is 1, add the multiplicand to the upper N bits of the accumulator with carry-out kept, then shift the {carry, accumulator} pair right by 1.
  - Increment counter. After the Nth iteration (counter = N-1 at the edge), go to FIX.
- FIX: product <= neg ? two's complement of the accumulator (2N bits) : accumulator. Go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 at this edge: accept the new operation as in IDLE and go to CALC.
  - Otherwise go to IDLE.
- Latency:
  - start sampled at edge E.
  - product valid after edge E+N+1.
  - done high for the cycle between edges E+N+1 and E+N+2.
  - Back-to-back throughput is one result per N+2 cycles.
- busy=1 exactly in CALC and FIX. done and busy are never high together.
- start while busy: ignored, with no effect on the current operation.
- Changing a, b or signed_mode after acceptance has no effect on the result.
- product is not modified during CALC. It changes only in FIX and on reset.
- Unsigned result range is 0..(2^N-1)^2. Signed result range is -(2^(N-1))(2^(N-1)-1)..2^(2N-2). All results fit exactly in 2N bits with no overflow.
- A zero operand still takes the full N+2 cycles. There is no early termination.

Test Plan:
- N=8, unsigned, a=0xFF, b=0xFF, start for one cycle → done pulses once, 10 cycles after the start edge; product=0xFE01; busy high for 9 cycles.
- N=8, signed, a=0x80 (-128), b=0x80 → product=0x4000. Then a=0x80, b=0x7F → product=0xC080 (-16256).
- N=8, signed, a=0xFD (-3), b=0x05 → product=0xFFF1. Repeat the same operands in unsigned mode → product=0x04F1 (253*5=1265).
- Start accepted with a=7, b=6; toggle a, b, signed_mode and pulse start during CALC → product=0x002A; done pulses exactly once; the extra starts are ignored.
- Assert start in the DONE cycle with a=0, b=0x55 → back-to-back operation accepted; first product is held until the FIX of the second; second product=0x0000; done pulses spaced exactly 10 cycles apart.
- Assert rst asynchronously (between clock edges) mid-CALC → product=0, busy=0 and done=0 immediately. After release, a new start with a=3, b=4 gives 0x000C with normal latency.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier with runtime signed/unsigned mode.
// Operands are latched on start; the product is held until the next FIX.
module seq_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic             neg_reg, neg_next;
    logic [N-1:0]     mcand_reg, mcand_next;
    logic [N-1:0]     mplier_reg, mplier_next;
    logic [2*N-1:0]   acc_reg, acc_next;
    logic [2*N-1:0]   product_reg, product_next;
    logic [CW-1:0]    count_reg, count_next;

    logic [N-1:0]     a_mag, b_mag;
    logic [N:0]       sum;

    // Signed operands are reduced to magnitudes; -2^(N-1) maps onto itself,
    // which is the correct unsigned magnitude.
    assign a_mag = (signed_mode && a[N-1]) ? -a : a;
    assign b_mag = (signed_mode && b[N-1]) ? -b : b;

    assign sum = {1'b0, acc_reg[2*N-1:N]} + {1'b0, (mplier_reg[0] ? mcand_reg : '0)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            neg_reg     <= 1'b0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            product_reg <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            neg_reg     <= neg_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            acc_reg     <= acc_next;
            product_reg <= product_next;
            count_reg   <= count_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        neg_next     = neg_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        acc_next     = acc_reg;
        product_next = product_reg;
        count_next   = count_reg;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                done = (state_reg == DONE);
                if (start) begin
                    state_next  = CALC;
                    neg_next    = signed_mode & (a[N-1] ^ b[N-1]);
                    mcand_next  = a_mag;
                    mplier_next = b_mag;
                    acc_next    = '0;
                    count_next  = '0;
                end else begin
                    state_next  = IDLE;
                end
            end
            CALC: begin
                busy        = 1'b1;
                // Carry from the add lands in the MSB after the right shift.
                acc_next    = {sum, acc_reg[N-1:1]};
                mplier_next = mplier_reg >> 1;
                count_next  = count_reg + 1'b1;
                if (count_reg == CW'(N - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy         = 1'b1;
                product_next = neg_reg ? -acc_reg : acc_reg;
                state_next   = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign product = product_reg;

endmodule
